display_slot_arbiter: RTL and testbench
=======================================

// Module: display_slot_arbiter
// PURPOSE
//   Shares the single 7-segment display between N_REQ requesters (e.g. mood, hunger, alarm glyphs).
//   Owns the MAX_COUNT prescaler that sets the display timebase.
//   Grants the display round-robin for HOLD_TICKS ticks per slot, with a blank gap of BLANK_TICKS ticks between slots.
//   Sits between the game-state logic and uo_out[6:0] inside tt_um_jleugeri_demon_baby.
// PARAMETERS
//   MAX_COUNT    10_000_000  clk cycles per tick; must be >= 2 (bench uses 4)
//   N_REQ        3           number of requesters; 2..8
//   HOLD_TICKS   2           ticks a granted glyph is shown; must be >= 1
//   BLANK_TICKS  1           ticks of blank display between slots; 0 = no gap
// PORTS
//   clk       in   1          system clock
//   reset     in   1          synchronous, active-high reset (top level drives it from ~rst_n)
//   req       in   N_REQ      level request per requester; held while it wants the display
//   glyph     in   7*N_REQ    segment pattern per requester; requester i uses glyph[7*i +: 7]
//   grant     out  N_REQ      one-hot owner of the display; all-zero when no owner
//   segments  out  7          registered segment drive to uo_out[6:0]
//   tick      out  1          one-cycle pulse when the prescaler wraps
//   busy      out  1          high in SHOW or BLANK
// BEHAVIOUR
//   Reset state: grant=0, segments=0, tick=0, busy=0, prescaler=0, state=IDLE.
//     - rr_last = N_REQ-1, so requester 0 wins first.
//   Prescaler: free-running counter, $clog2(MAX_COUNT) bits, counts 0..MAX_COUNT-1.
//     - tick=1 on the cycle the count equals MAX_COUNT-1; the count then wraps to 0.
//     - It is never cleared by grants, so the first tick of a slot may arrive early (partial slot).
//   FSM states: IDLE, SHOW, BLANK. All outputs are registered.
//   IDLE: grant=0, segments=0.
//     - If any req bit is high, pick the first requester at or after (rr_last+1) mod N_REQ, wrapping.
//     - On the next edge: state=SHOW, grant=onehot(winner), segments=glyph[winner], hold_cnt=HOLD_TICKS, rr_last=winner.
//     - Grant and glyph appear 1 cycle after req is seen.
//   SHOW: segments <= glyph[owner] every cycle, so glyph changes show 1 cycle later.
//     - If req[owner]=0, leave SHOW on the next edge; this takes priority over tick.
//     - On tick: if hold_cnt==1, leave SHOW; otherwise hold_cnt decrements.
//     - Leaving SHOW: if BLANK_TICKS>0, go to BLANK with blank_cnt=BLANK_TICKS; otherwise go to IDLE.
//       Either way grant=0 and segments=0 on that edge.
//     - Requests from other requesters never preempt the owner.
//   BLANK: grant=0, segments=0.
//     - Each tick decrements blank_cnt; on the tick where blank_cnt==1, go to IDLE.
//     - req is ignored during BLANK.
//   busy = (state != IDLE). No combinational path from inputs to outputs.
//   A reset asserted in any state forces the reset values at the next edge.
//     - Any in-progress slot is aborted and the prescaler phase is lost.
//   glyph bits of non-owners are don't-care; req may change on any cycle.
// TESTING  (MAX_COUNT=4, N_REQ=3, HOLD_TICKS=2, BLANK_TICKS=1)
//   1. Hold reset 3 cycles with req=3'b111 -> grant=0, segments=0, tick=0, busy=0.
//      After release, tick pulses exactly on every 4th cycle, never back-to-back.
//   2. req=001, glyph0=7'h3F -> next cycle grant=001, segments=3F.
//      Display clears on the 2nd tick. It stays 0 until the next tick, then grant=001 again.
//   3. req=111 held -> successive grants 001, 010, 100, 001, each followed by one blank tick.
//   4. req=010 granted, then req[1] drops mid-slot -> next cycle grant=0, segments=0, state=BLANK.
//   5. In SHOW, glyph1 changes 7'h06 -> 7'h5B -> segments=5B exactly 1 cycle later.
//   6. Assert reset mid-SHOW with owner=2 -> outputs zero next edge.
//      After release with req=111, requester 0 is granted first.

Source files
------------

// File: rtl/display_slot_arbiter_if.sv
// ---------------------------------------------------------------------------
// display_slot_arbiter_if
//   Bundles the requester-facing signals of the display slot arbiter.
//   master : requester / game-state side (drives req and glyph)
//   slave  : arbiter side (drives grant, segments, tick, busy)
// Signals
//   req       N_REQ     level request per requester
//   glyph     7*N_REQ   segment pattern per requester, glyph[7*i +: 7]
//   grant     N_REQ     one-hot display owner, zero when no owner
//   segments  7         registered segment drive
//   tick      1         one-cycle prescaler wrap pulse
//   busy      1         high while a slot or its blank gap is in progress
// ---------------------------------------------------------------------------
interface display_slot_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]   req;
    logic [7*N_REQ-1:0] glyph;
    logic [N_REQ-1:0]   grant;
    logic [6:0]         segments;
    logic               tick;
    logic               busy;

    modport master (
        output req,
        output glyph,
        input  grant,
        input  segments,
        input  tick,
        input  busy
    );

    modport slave (
        input  req,
        input  glyph,
        output grant,
        output segments,
        output tick,
        output busy
    );
endinterface

// File: rtl/display_slot_arbiter.sv
// ---------------------------------------------------------------------------
// display_slot_arbiter
//   Shares one 7-segment display between N_REQ requesters. A free-running
//   prescaler defines the display timebase (tick). The display is granted
//   round-robin for HOLD_TICKS ticks per slot, followed by BLANK_TICKS ticks
//   of blank display before the next slot. All outputs are registered.
// Ports
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   bus      display_slot_arbiter_if.slave (req, glyph in; grant, segments,
//            tick, busy out)
// ---------------------------------------------------------------------------
module display_slot_arbiter #(
    parameter int MAX_COUNT   = 10_000_000,
    parameter int N_REQ       = 3,
    parameter int HOLD_TICKS  = 2,
    parameter int BLANK_TICKS = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    display_slot_arbiter_if.slave  bus
);

    localparam int CW = $clog2(MAX_COUNT);
    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = (BLANK_TICKS > 0) ? $clog2(BLANK_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_presc;
    logic               r_tick;
    logic [N_REQ-1:0]   r_grant;
    logic [6:0]         r_segments;
    logic               r_busy;
    logic [IW-1:0]      r_rr_last;   // last winner; also the current owner while in SHOW
    logic [HW-1:0]      r_hold;
    logic [BW-1:0]      r_blank;

    logic [IW-1:0]      w_winner;
    logic               w_found;
    logic               w_owner_req;
    logic [6:0]         w_owner_glyph;
    logic [6:0]         w_winner_glyph;
    logic [N_REQ-1:0]   w_winner_onehot;
    int                 v_idx;

    // Prescaler: tick is registered one cycle ahead so it is high exactly
    // while the count sits at MAX_COUNT-1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            if (r_presc == CW'(MAX_COUNT - 1)) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + CW'(1);
            end
            r_tick <= (r_presc == CW'(MAX_COUNT - 2));
        end
    end

    // Round-robin search: first requesting index at or after rr_last+1, wrapping.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        v_idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            v_idx = int'(r_rr_last) + k;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end else begin
                v_idx = v_idx;
            end
            if (!w_found && bus.req[v_idx]) begin
                w_found  = 1'b1;
                w_winner = IW'(v_idx);
            end else begin
                w_found  = w_found;
            end
        end
    end

    assign w_owner_req     = bus.req[r_rr_last];
    assign w_owner_glyph   = bus.glyph[7*int'(r_rr_last) +: 7];
    assign w_winner_glyph  = bus.glyph[7*int'(w_winner) +: 7];
    assign w_winner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;

    // Slot FSM with registered grant, segments and busy.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_segments <= 7'h00;
            r_busy     <= 1'b0;
            r_rr_last  <= IW'(N_REQ - 1);
            r_hold     <= '0;
            r_blank    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_SHOW;
                        r_grant    <= w_winner_onehot;
                        r_segments <= w_winner_glyph;
                        r_busy     <= 1'b1;
                        r_rr_last  <= w_winner;
                        r_hold     <= HW'(HOLD_TICKS);
                    end else begin
                        r_grant    <= '0;
                        r_segments <= 7'h00;
                        r_busy     <= 1'b0;
                    end
                end
                ST_SHOW: begin
                    // A dropped request ends the slot before any tick is considered.
                    if (!w_owner_req || (r_tick && (r_hold == HW'(1)))) begin
                        r_grant    <= '0;
                        r_segments <= 7'h00;
                        if (BLANK_TICKS > 0) begin
                            r_state <= ST_BLANK;
                            r_blank <= BW'(BLANK_TICKS);
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_segments <= w_owner_glyph;
                        if (r_tick) begin
                            r_hold <= r_hold - HW'(1);
                        end else begin
                            r_hold <= r_hold;
                        end
                    end
                end
                ST_BLANK: begin
                    r_grant    <= '0;
                    r_segments <= 7'h00;
                    if (r_tick && (r_blank == BW'(1))) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_tick) begin
                        r_blank <= r_blank - BW'(1);
                    end else begin
                        r_blank <= r_blank;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_grant    <= '0;
                    r_segments <= 7'h00;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant    = r_grant;
    assign bus.segments = r_segments;
    assign bus.tick     = r_tick;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_display_slot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_display_slot_arbiter
//   Directed bench for display_slot_arbiter with MAX_COUNT=4, N_REQ=3,
//   HOLD_TICKS=2, BLANK_TICKS=1. Expected values are hand-derived from the
//   prescaler phase: after reset release, edge k leaves the count at k mod 4
//   and tick is high after edges where k mod 4 == 3.
// ---------------------------------------------------------------------------
module tb_display_slot_arbiter;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    int   cyc;

    display_slot_arbiter_if #(.N_REQ(3)) bus ();

    display_slot_arbiter #(
        .MAX_COUNT   (4),
        .N_REQ       (3),
        .HOLD_TICKS  (2),
        .BLANK_TICKS (1)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle past it before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    endtask

    task automatic chk_out(input string tag, input logic [2:0] g, input logic [6:0] s, input logic b);
        chk({tag, ".grant"},    32'(bus.grant),    32'(g));
        chk({tag, ".segments"}, 32'(bus.segments), 32'(s));
        chk({tag, ".busy"},     32'(bus.busy),     32'(b));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        reset   = 1'b1;
        bus.req   = 3'b111;
        bus.glyph = {7'h4F, 7'h06, 7'h3F};

        // 1. reset held three cycles with all requests high
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("reset_hold", 3'b000, 7'h00, 1'b0);
            chk("reset_hold.tick", 32'(bus.tick), 32'd0);
        end
        reset   = 1'b0;
        bus.req = 3'b000;
        cyc     = 0;

        // tick pulses on every 4th cycle, never back-to-back
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("tick_phase", 32'(bus.tick), ((k % 4) == 3) ? 32'd1 : 32'd0);
        end

        // 2. single requester 0
        bus.req = 3'b001;
        step();                                   // cyc 13
        chk_out("grant0_first", 3'b001, 7'h3F, 1'b1);
        step_to(19);
        chk_out("grant0_held", 3'b001, 7'h3F, 1'b1);
        step();                                   // cyc 20: second tick ends slot
        chk_out("grant0_clear", 3'b000, 7'h00, 1'b1);
        step_to(23);
        chk_out("blank_hold", 3'b000, 7'h00, 1'b1);
        step();                                   // cyc 24: blank tick -> IDLE
        chk_out("blank_done", 3'b000, 7'h00, 1'b0);
        step();                                   // cyc 25
        chk_out("grant0_again", 3'b001, 7'h3F, 1'b1);

        // 3. all requesting: round-robin 001 -> 010 -> 100 -> 001
        bus.req = 3'b111;
        step_to(31);
        chk_out("rr_show0_end", 3'b001, 7'h3F, 1'b1);
        step();                                   // cyc 32
        chk_out("rr_blank0", 3'b000, 7'h00, 1'b1);
        step_to(36);
        chk_out("rr_idle0", 3'b000, 7'h00, 1'b0);
        step();                                   // cyc 37
        chk_out("rr_grant1", 3'b010, 7'h06, 1'b1);
        step_to(44);
        chk_out("rr_blank1", 3'b000, 7'h00, 1'b1);
        step_to(49);
        chk_out("rr_grant2", 3'b100, 7'h4F, 1'b1);
        step_to(61);
        chk_out("rr_grant0_wrap", 3'b001, 7'h3F, 1'b1);

        // 4. owner 0 drops its request; requester 1 waits for the gap
        bus.req = 3'b010;
        step();                                   // cyc 62
        chk_out("drop0_blank", 3'b000, 7'h00, 1'b1);
        step_to(64);
        chk_out("drop0_idle", 3'b000, 7'h00, 1'b0);
        step();                                   // cyc 65
        chk_out("grant1", 3'b010, 7'h06, 1'b1);

        // 5. glyph change while shown appears one cycle later
        bus.glyph[13:7] = 7'h5B;
        step();                                   // cyc 66
        chk_out("glyph_update", 3'b010, 7'h5B, 1'b1);

        // req[1] drops mid-slot
        bus.req = 3'b000;
        step();                                   // cyc 67
        chk_out("drop1_blank", 3'b000, 7'h00, 1'b1);
        step();                                   // cyc 68
        chk_out("drop1_idle", 3'b000, 7'h00, 1'b0);

        // 6. reset mid-SHOW with owner 2
        bus.req = 3'b100;
        step();                                   // cyc 69
        chk_out("grant2", 3'b100, 7'h4F, 1'b1);
        reset   = 1'b1;
        bus.req = 3'b111;
        step();                                   // cyc 70
        chk_out("reset_mid", 3'b000, 7'h00, 1'b0);
        chk("reset_mid.tick", 32'(bus.tick), 32'd0);
        reset = 1'b0;
        step();                                   // cyc 71
        chk_out("post_reset_grant0", 3'b001, 7'h3F, 1'b1);
        step();                                   // cyc 72
        chk("post_reset_tick_lo", 32'(bus.tick), 32'd0);
        step();                                   // cyc 73
        chk("post_reset_tick_hi", 32'(bus.tick), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
